// File: rtl/e203_nts_ctx_mover_pkg.sv
// Shared constants for the NTS context mover: RAM geometry, frame size and FSM state encoding.
package e203_nts_ctx_mover_pkg;

  // Mirrors the core defines for the NTS RAM instance in the SRAM wrapper.
  localparam int NTS_RAM_AW      = 6;
  localparam int NTS_RAM_DW      = 32;
  localparam int NTS_RAM_MW      = NTS_RAM_DW / 8;
  localparam int NTS_FRAME_WORDS = 16;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_SAVE    = 2'd1;
  localparam logic [1:0] ST_RESTORE = 2'd2;
  localparam logic [1:0] ST_RDRAIN  = 2'd3;

endpackage

// File: rtl/e203_nts_ctx_rdpipe.sv
// Read-return stage: tracks the word in flight from NTS RAM and steers it into the register file.
module e203_nts_ctx_rdpipe
  import e203_nts_ctx_mover_pkg::*;
#(
  parameter int DW = NTS_RAM_DW
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          rd_issue_i,
  input  logic [4:0]    rd_idx_i,
  input  logic [DW-1:0] ram_dout_i,
  output logic          rf_wr_en_o,
  output logic [4:0]    rf_wr_idx_o,
  output logic [DW-1:0] rf_wr_data_o
);

  logic       rd_vld_q;
  logic [4:0] rd_idx_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) rd_vld_q <= 1'b0;
    else         rd_vld_q <= rd_issue_i;
  end

  // Index is only meaningful while rd_vld_q is set, so it needs no reset.
  always_ff @(posedge clk_i) begin
    if (rd_issue_i) rd_idx_q <= rd_idx_i;
  end

  assign rf_wr_en_o   = rd_vld_q;
  assign rf_wr_idx_o  = rd_vld_q ? rd_idx_q   : '0;
  assign rf_wr_data_o = rd_vld_q ? ram_dout_i : '0;

endmodule

// File: rtl/e203_nts_ctx_mover.sv
// Context save/restore engine: streams NREG register-file words to/from a frame in NTS RAM.
module e203_nts_ctx_mover
  import e203_nts_ctx_mover_pkg::*;
#(
  parameter int AW   = NTS_RAM_AW,
  parameter int DW   = NTS_RAM_DW,
  parameter int MW   = NTS_RAM_MW,
  parameter int NREG = NTS_FRAME_WORDS,
  parameter int BASE = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          save_req,
  input  logic          restore_req,
  input  logic          frame_sel,
  output logic          busy,
  output logic          save_done,
  output logic          restore_done,
  output logic [4:0]    rf_rd_idx,
  input  logic [DW-1:0] rf_rd_data,
  output logic          rf_wr_en,
  output logic [4:0]    rf_wr_idx,
  output logic [DW-1:0] rf_wr_data,
  output logic          nts_ram_cs,
  output logic          nts_ram_we,
  output logic [AW-1:0] nts_ram_addr,
  output logic [MW-1:0] nts_ram_wem,
  output logic [DW-1:0] nts_ram_din,
  input  logic [DW-1:0] nts_ram_dout
);

  localparam int            CW          = (NREG > 1) ? $clog2(NREG) : 1;
  localparam logic [AW-1:0] FRAME0_BASE = AW'(BASE);
  localparam logic [AW-1:0] FRAME1_BASE = AW'(BASE + NREG);
  localparam logic [CW-1:0] LAST_CNT    = CW'(NREG - 1);

  // Write-back index is 5 bits wide, which bounds the frame size.
  if (NREG < 2 || NREG > 32 || NREG > (1 << AW)) begin : g_nreg_check
    $error("e203_nts_ctx_mover: NREG must lie in 2..min(32, 2**AW)");
  end

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          frame_q, frame_d;
  logic          save_done_q, save_done_d;
  logic          restore_done_q, restore_done_d;
  logic          rd_issue;
  logic [4:0]    cnt_idx;
  logic [AW-1:0] addr_w;
  logic          last_w;

  assign cnt_idx = 5'(cnt_q);
  assign addr_w  = (frame_q ? FRAME1_BASE : FRAME0_BASE) + AW'(cnt_q);
  assign last_w  = (cnt_q == LAST_CNT);

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    frame_d        = frame_q;
    save_done_d    = 1'b0;
    restore_done_d = 1'b0;
    rd_issue       = 1'b0;
    rf_rd_idx      = '0;
    nts_ram_cs     = 1'b0;
    nts_ram_we     = 1'b0;
    nts_ram_addr   = '0;
    nts_ram_wem    = '0;
    nts_ram_din    = '0;
    case (state_q)
      ST_IDLE: begin
        // Save has priority; a simultaneous restore request is dropped.
        if (save_req || restore_req) begin
          state_d = save_req ? ST_SAVE : ST_RESTORE;
          cnt_d   = '0;
          frame_d = frame_sel;
        end
      end
      ST_SAVE: begin
        rf_rd_idx    = cnt_idx;
        nts_ram_cs   = 1'b1;
        nts_ram_we   = 1'b1;
        nts_ram_wem  = '1;
        nts_ram_addr = addr_w;
        nts_ram_din  = rf_rd_data;
        cnt_d        = last_w ? '0 : cnt_q + CW'(1);
        if (last_w) begin
          state_d     = ST_IDLE;
          save_done_d = 1'b1;
        end
      end
      ST_RESTORE: begin
        nts_ram_cs   = 1'b1;
        nts_ram_addr = addr_w;
        rd_issue     = 1'b1;
        cnt_d        = last_w ? '0 : cnt_q + CW'(1);
        if (last_w) state_d = ST_RDRAIN;
      end
      ST_RDRAIN: begin
        // Last read returns this cycle; done is flagged in the first idle cycle.
        state_d        = ST_IDLE;
        restore_done_d = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      frame_q        <= 1'b0;
      save_done_q    <= 1'b0;
      restore_done_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      frame_q        <= frame_d;
      save_done_q    <= save_done_d;
      restore_done_q <= restore_done_d;
    end
  end

  assign busy         = (state_q != ST_IDLE);
  assign save_done    = save_done_q;
  assign restore_done = restore_done_q;

  e203_nts_ctx_rdpipe #(.DW(DW)) u_rdpipe (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .rd_issue_i   (rd_issue),
    .rd_idx_i     (cnt_idx),
    .ram_dout_i   (nts_ram_dout),
    .rf_wr_en_o   (rf_wr_en),
    .rf_wr_idx_o  (rf_wr_idx),
    .rf_wr_data_o (rf_wr_data)
  );

endmodule

// File: tb/tb_e203_nts_ctx_mover.sv
// Randomised bench for e203_nts_ctx_mover against a frame-level model of RAM and register file.
module tb_e203_nts_ctx_mover;

  localparam int AW = 6, DW = 32, MW = 4, NREG = 16, BASE = 0;
  localparam int AW1 = 4, NREG1 = 8, BASE1 = 12;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          save_req = 1'b0, restore_req = 1'b0, frame_sel = 1'b0;
  logic          busy, save_done, restore_done;
  logic [4:0]    rf_rd_idx, rf_wr_idx;
  logic [DW-1:0] rf_rd_data, rf_wr_data;
  logic          rf_wr_en;
  logic          nts_ram_cs, nts_ram_we;
  logic [AW-1:0] nts_ram_addr;
  logic [MW-1:0] nts_ram_wem;
  logic [DW-1:0] nts_ram_din;
  logic [DW-1:0] nts_ram_dout;

  logic          save_req1 = 1'b0, restore_req1 = 1'b0, frame_sel1 = 1'b0;
  logic          busy1, save_done1, restore_done1;
  logic [4:0]    rf_rd_idx1, rf_wr_idx1;
  logic [DW-1:0] rf_rd_data1, rf_wr_data1;
  logic          rf_wr_en1;
  logic          cs1, we1;
  logic [AW1-1:0] addr1;
  logic [MW-1:0] wem1;
  logic [DW-1:0] din1;
  logic [DW-1:0] dout1 = '0;

  e203_nts_ctx_mover #(.AW(AW), .DW(DW), .MW(MW), .NREG(NREG), .BASE(BASE)) dut (
    .clk(clk), .rst_n(rst_n), .save_req(save_req), .restore_req(restore_req),
    .frame_sel(frame_sel), .busy(busy), .save_done(save_done), .restore_done(restore_done),
    .rf_rd_idx(rf_rd_idx), .rf_rd_data(rf_rd_data), .rf_wr_en(rf_wr_en),
    .rf_wr_idx(rf_wr_idx), .rf_wr_data(rf_wr_data), .nts_ram_cs(nts_ram_cs),
    .nts_ram_we(nts_ram_we), .nts_ram_addr(nts_ram_addr), .nts_ram_wem(nts_ram_wem),
    .nts_ram_din(nts_ram_din), .nts_ram_dout(nts_ram_dout)
  );

  e203_nts_ctx_mover #(.AW(AW1), .DW(DW), .MW(MW), .NREG(NREG1), .BASE(BASE1)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .save_req(save_req1), .restore_req(restore_req1),
    .frame_sel(frame_sel1), .busy(busy1), .save_done(save_done1), .restore_done(restore_done1),
    .rf_rd_idx(rf_rd_idx1), .rf_rd_data(rf_rd_data1), .rf_wr_en(rf_wr_en1),
    .rf_wr_idx(rf_wr_idx1), .rf_wr_data(rf_wr_data1), .nts_ram_cs(cs1),
    .nts_ram_we(we1), .nts_ram_addr(addr1), .nts_ram_wem(wem1),
    .nts_ram_din(din1), .nts_ram_dout(dout1)
  );

  // Environment: RAM and register file seen by the DUT, loadable from the model.
  logic [DW-1:0] ram [0:63];
  logic [DW-1:0] rf  [0:31];
  logic [DW-1:0] ref_mem [0:63];
  logic [DW-1:0] rf_ref  [0:31];
  logic          load_en = 1'b0;

  assign rf_rd_data  = rf[rf_rd_idx];
  assign rf_rd_data1 = {27'h2A5A5A5, rf_rd_idx1};

  always @(posedge clk) begin
    if (load_en) begin
      for (int k = 0; k < 64; k++) ram[k] <= ref_mem[k];
      for (int k = 0; k < 32; k++) rf[k] <= rf_ref[k];
    end else begin
      if (nts_ram_cs && nts_ram_we) begin
        for (int b = 0; b < MW; b++)
          if (nts_ram_wem[b]) ram[nts_ram_addr][b*8 +: 8] <= nts_ram_din[b*8 +: 8];
      end else if (nts_ram_cs) begin
        nts_ram_dout <= ram[nts_ram_addr];
      end
      if (rf_wr_en) rf[rf_wr_idx] <= rf_wr_data;
    end
  end

  int checks = 0;
  int failures = 0;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [AW-1:0] frame_addr(input logic f, input int i);
    return AW'((BASE + int'(f) * NREG + i) % (1 << AW));
  endfunction

  task automatic load_env();
    load_en = 1'b1;
    @(posedge clk); #1;
    load_en = 1'b0;
  endtask

  task automatic randomize_model();
    for (int k = 0; k < 64; k++) ref_mem[k] = $urandom;
    for (int k = 0; k < 32; k++) rf_ref[k] = $urandom;
    load_env();
  endtask

  task automatic issue(input logic s, input logic r, input logic f);
    save_req = s; restore_req = r; frame_sel = f;
    @(posedge clk); #1;
    save_req = 1'b0; restore_req = 1'b0; frame_sel = 1'(($urandom));
  endtask

  // Checks NREG write beats then the done cycle; optionally pokes restore_req mid-save.
  task automatic save_body(input logic f, input int poke_at);
    logic [AW-1:0] ea;
    for (int i = 0; i < NREG; i++) begin
      @(negedge clk);
      ea = frame_addr(f, i);
      checks++;
      if ({busy, save_done, restore_done, nts_ram_cs, nts_ram_we, nts_ram_wem, rf_wr_en} !== {3'b100, 2'b11, 4'hF, 1'b0}
          || nts_ram_addr !== ea || nts_ram_din !== rf_ref[i] || rf_rd_idx !== 5'(i)) begin
        failures++;
        $display("FAIL save_beat%0d: got busy=%0b cs=%0b we=%0b wem=%h addr=%0d din=%h idx=%0d, want addr=%0d din=%h",
                 i, busy, nts_ram_cs, nts_ram_we, nts_ram_wem, nts_ram_addr, nts_ram_din, rf_rd_idx, ea, rf_ref[i]);
      end
      ref_mem[ea] = rf_ref[i];
      @(posedge clk); #1;
      restore_req = (i == poke_at);
    end
    restore_req = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, save_done, restore_done, nts_ram_cs} !== 4'b0100) begin
      failures++;
      $display("FAIL save_done: got busy=%0b save_done=%0b restore_done=%0b cs=%0b, want 0 1 0 0",
               busy, save_done, restore_done, nts_ram_cs);
    end
  endtask

  // Checks read beats, delayed write-back, drain and done; stop_after>0 returns early.
  task automatic restore_body(input logic f, input int stop_after);
    logic [AW-1:0] ea;
    logic          bad;
    for (int i = 0; i < NREG; i++) begin
      @(negedge clk);
      ea = frame_addr(f, i);
      checks++;
      if ({busy, save_done, restore_done, nts_ram_cs, nts_ram_we, nts_ram_wem} !== {3'b100, 2'b10, 4'h0}
          || nts_ram_addr !== ea || nts_ram_din !== '0 || rf_rd_idx !== 5'd0) begin
        failures++;
        $display("FAIL restore_read%0d: got busy=%0b cs=%0b we=%0b wem=%h addr=%0d din=%h, want addr=%0d",
                 i, busy, nts_ram_cs, nts_ram_we, nts_ram_wem, nts_ram_addr, nts_ram_din, ea);
      end
      checks++;
      if (i == 0) begin
        if (rf_wr_en !== 1'b0) begin
          failures++;
          $display("FAIL restore_wb_first: got rf_wr_en=%0b, want 0", rf_wr_en);
        end
      end else begin
        if (rf_wr_en !== 1'b1 || rf_wr_idx !== 5'(i - 1) || rf_wr_data !== ref_mem[frame_addr(f, i - 1)]) begin
          failures++;
          $display("FAIL restore_wb%0d: got en=%0b idx=%0d data=%h, want 1 %0d %h",
                   i - 1, rf_wr_en, rf_wr_idx, rf_wr_data, i - 1, ref_mem[frame_addr(f, i - 1)]);
        end
        rf_ref[i - 1] = ref_mem[frame_addr(f, i - 1)];
      end
      @(posedge clk); #1;
      if (i + 1 == stop_after) return;
    end
    @(negedge clk);
    ea = frame_addr(f, NREG - 1);
    checks++;
    if ({busy, save_done, restore_done, nts_ram_cs, rf_wr_en} !== 5'b10001 || nts_ram_addr !== '0
        || rf_wr_idx !== 5'(NREG - 1) || rf_wr_data !== ref_mem[ea]) begin
      failures++;
      $display("FAIL restore_drain: got busy=%0b done=%0b cs=%0b en=%0b idx=%0d data=%h, want 1 0 0 1 %0d %h",
               busy, restore_done, nts_ram_cs, rf_wr_en, rf_wr_idx, rf_wr_data, NREG - 1, ref_mem[ea]);
    end
    rf_ref[NREG - 1] = ref_mem[ea];
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if ({busy, save_done, restore_done, rf_wr_en, nts_ram_cs} !== 5'b00100) begin
      failures++;
      $display("FAIL restore_done: got busy=%0b save_done=%0b restore_done=%0b en=%0b cs=%0b, want 0 0 1 0 0",
               busy, save_done, restore_done, rf_wr_en, nts_ram_cs);
    end
    bad = 1'b0;
    for (int k = 0; k < NREG; k++) if (rf[k] !== rf_ref[k]) bad = 1'b1;
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL restore_rf_contents: got rf[0]=%h rf[%0d]=%h, want %h %h",
               rf[0], NREG - 1, rf[NREG - 1], rf_ref[0], rf_ref[NREG - 1]);
    end
  endtask

  task automatic check_all_zero(input string tag);
    checks++;
    if ({busy, save_done, restore_done, rf_rd_idx, rf_wr_en, rf_wr_idx, rf_wr_data,
         nts_ram_cs, nts_ram_we, nts_ram_addr, nts_ram_wem, nts_ram_din} !== '0) begin
      failures++;
      $display("FAIL %s: got busy=%0b done=%0b/%0b en=%0b cs=%0b we=%0b addr=%0d wem=%h din=%h, want all 0",
               tag, busy, save_done, restore_done, rf_wr_en, nts_ram_cs, nts_ram_we,
               nts_ram_addr, nts_ram_wem, nts_ram_din);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    randomize_model();
    @(negedge clk);
    check_all_zero("reset_outputs");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_all_zero("idle_after_reset");
  endtask

  task automatic test_save();
    for (int k = 0; k < NREG; k++) rf_ref[k] = 32'hA5A50000 + k;
    for (int k = 0; k < NREG; k++) ref_mem[16 + k] = 32'h1000 + k;
    load_env();
    issue(1'b1, 1'b0, 1'b0);
    save_body(1'b0, -1);
  endtask

  task automatic test_restore();
    @(posedge clk); #1;
    issue(1'b0, 1'b1, 1'b1);
    restore_body(1'b1, 0);
    checks++;
    if (rf[5] !== 32'h1005) begin
      failures++;
      $display("FAIL restore_rf5: got %h, want 00001005", rf[5]);
    end
  endtask

  task automatic test_collision();
    logic f;
    f = 1'(($urandom));
    @(posedge clk); #1;
    issue(1'b1, 1'b1, f);
    save_body(f, 3);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if ({busy, restore_done, nts_ram_cs, rf_wr_en} !== 4'b0000) begin
        failures++;
        $display("FAIL collision_idle%0d: got busy=%0b restore_done=%0b cs=%0b en=%0b, want 0",
                 c, busy, restore_done, nts_ram_cs, rf_wr_en);
      end
    end
  endtask

  task automatic test_random();
    logic f;
    for (int n = 0; n < 6; n++) begin
      randomize_model();
      f = 1'(($urandom));
      if ($urandom_range(1, 0) == 1) begin
        issue(1'b1, 1'b0, f);
        save_body(f, -1);
      end else begin
        issue(1'b0, 1'b1, f);
        restore_body(f, 0);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    logic f;
    randomize_model();
    f = 1'(($urandom));
    issue(1'b1, 1'b0, f);
    save_body(f, -1);
    f = ~f;
    issue(1'b1, 1'b0, f);
    save_body(f, -1);
    issue(1'b0, 1'b1, f);
    restore_body(f, 0);
    issue(1'b0, 1'b1, ~f);
    restore_body(~f, 0);
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_restore();
    logic f;
    randomize_model();
    f = 1'(($urandom));
    rf_ref[4] = 32'hDEADBEEF;
    ref_mem[frame_addr(f, 4)] = 32'h21524110;
    load_env();
    issue(1'b0, 1'b1, f);
    restore_body(f, 5);
    rst_n = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check_all_zero("reset_mid_restore");
      @(posedge clk); #1;
    end
    rst_n = 1'b1;
    @(negedge clk);
    check_all_zero("after_mid_reset");
    checks++;
    if (rf[4] !== 32'hDEADBEEF || rf[3] !== rf_ref[3]) begin
      failures++;
      $display("FAIL mid_reset_rf: got rf[3]=%h rf[4]=%h, want %h deadbeef", rf[3], rf[4], rf_ref[3]);
    end
    @(posedge clk); #1;
    f = 1'(($urandom));
    issue(1'b1, 1'b0, f);
    save_body(f, -1);
    @(posedge clk); #1;
  endtask

  task automatic test_wrap();
    logic [AW1-1:0] ea;
    for (int f = 0; f < 2; f++) begin
      save_req1 = 1'b1; frame_sel1 = 1'(f);
      @(posedge clk); #1;
      save_req1 = 1'b0; frame_sel1 = 1'(($urandom));
      for (int i = 0; i < NREG1; i++) begin
        @(negedge clk);
        ea = AW1'((BASE1 + f * NREG1 + i) % 16);
        checks++;
        if ({busy1, cs1, we1, wem1} !== {3'b111, 4'hF} || addr1 !== ea || din1 !== {27'h2A5A5A5, 5'(i)}) begin
          failures++;
          $display("FAIL wrap_f%0d_beat%0d: got cs=%0b we=%0b addr=%0d din=%h, want addr=%0d din=%h",
                   f, i, cs1, we1, addr1, din1, ea, {27'h2A5A5A5, 5'(i)});
        end
        @(posedge clk); #1;
      end
      @(negedge clk);
      checks++;
      if ({busy1, save_done1, cs1} !== 3'b010) begin
        failures++;
        $display("FAIL wrap_done_f%0d: got busy=%0b save_done=%0b cs=%0b, want 0 1 0", f, busy1, save_done1, cs1);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_save();
    test_restore();
    test_collision();
    test_random();
    test_back_to_back();
    test_reset_mid_restore();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
